// File: rtl/alu_multicycle.sv
// alu_multicycle: per-thread ALU with single-cycle ADD/SUB/CMP and iterative unsigned MUL/DIV
//
// Ports:
//   clk                         rising-edge clock
//   reset                       asynchronous active-high reset
//   enable                      thread active; low freezes all state
//   core_state                  core FSM state; entering EXECUTE_STATE launches an op
//   decoded_alu_arithmetic_mux  00 ADD, 01 SUB, 10 MUL, 11 DIV
//   decoded_alu_output_mux      1 selects unsigned compare result
//   rs, rt                      operands A and B
//   alu_out                     registered result
//   alu_busy                    multi-cycle op in progress
//   alu_done                    one-cycle pulse when alu_out is updated
module alu_multicycle #(
    parameter int         DATA_WIDTH    = 8,
    parameter logic [2:0] EXECUTE_STATE = 3'b101
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2:0]            core_state,
    input  logic [1:0]            decoded_alu_arithmetic_mux,
    input  logic                  decoded_alu_output_mux,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  alu_busy,
    output logic                  alu_done
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MUL  = 2'b01;
    localparam logic [1:0] S_DIV  = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  out_q, out_d;
    logic          done_q, done_d;
    logic [2:0]    prev_q, prev_d;

    logic          launch;
    logic          in_exec;
    logic [W-1:0]  mul_acc;
    logic [W:0]    div_sh;
    logic          div_ge;
    logic [W-1:0]  div_rem;
    logic [W-1:0]  div_quo;

    assign in_exec = core_state == EXECUTE_STATE;
    assign launch  = in_exec && prev_q != EXECUTE_STATE && state_q == S_IDLE;

    // MUL: a_q is the shifting multiplicand, b_q the shifting multiplier, r_q the partial product.
    assign mul_acc = r_q + (b_q[0] ? a_q : '0);

    // DIV: b_q holds the dividend, shifted out MSB-first while quotient bits shift in.
    // A zero divisor always compares as "fits", yielding an all-ones quotient.
    assign div_sh  = {r_q, b_q[W-1]};
    assign div_ge  = div_sh >= {1'b0, a_q};
    assign div_rem = div_ge ? W'(div_sh - {1'b0, a_q}) : div_sh[W-1:0];
    assign div_quo = {b_q[W-2:0], div_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        out_d   = out_q;
        done_d  = 1'b0;
        prev_d  = enable ? core_state : prev_q;
        if (enable) begin
            if (state_q == S_IDLE) begin
                if (launch) begin
                    if (decoded_alu_output_mux) begin
                        out_d      = '0;
                        out_d[2:0] = {rs > rt, rs == rt, rs < rt};
                        done_d     = 1'b1;
                    end else if (!decoded_alu_arithmetic_mux[1]) begin
                        out_d  = decoded_alu_arithmetic_mux[0] ? rs - rt : rs + rt;
                        done_d = 1'b1;
                    end else begin
                        state_d = decoded_alu_arithmetic_mux[0] ? S_DIV : S_MUL;
                        a_d     = decoded_alu_arithmetic_mux[0] ? rt : rs;
                        b_d     = decoded_alu_arithmetic_mux[0] ? rs : rt;
                        r_d     = '0;
                        cnt_d   = '0;
                    end
                end
            end else if (!in_exec) begin
                // Abort takes priority over a final iteration on the same edge.
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
                a_d   = state_q == S_MUL ? a_q << 1 : a_q;
                b_d   = state_q == S_MUL ? b_q >> 1 : div_quo;
                r_d   = state_q == S_MUL ? mul_acc : div_rem;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    out_d   = state_q == S_MUL ? mul_acc : div_quo;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            out_q   <= out_d;
            done_q  <= done_d;
            prev_q  <= prev_d;
        end
    end

    assign alu_out  = out_q;
    assign alu_busy = state_q != S_IDLE;
    assign alu_done = done_q;
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised successor to the per-thread ALU wrapper in the tiny-gpu core datapath.
- Keeps single-cycle ADD/SUB/CMP.
- Adds iterative unsigned MUL and DIV, which hold the core in EXECUTE via a busy/done handshake.
- Width is configurable; sits between the register file (rs/rt) and the register write-back mux.

Parameters:
- DATA_WIDTH, 8, operand/result width in bits (must be >= 3).
- EXECUTE_STATE, 3'b101, core_state encoding that qualifies ALU launch.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  thread active; low freezes all state, including mid-operation.
- core_state  input  3  core FSM state.
- decoded_alu_arithmetic_mux  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- decoded_alu_output_mux  input  1  1 selects compare result, overrides arithmetic op.
- rs  input  DATA_WIDTH  operand A.
- rt  input  DATA_WIDTH  operand B.
- alu_out  output  DATA_WIDTH  registered result.
- alu_busy  output  1  multi-cycle op in progress.
- alu_done  output  1  one-cycle pulse: alu_out updated this cycle.

Behaviour:
- Reset (async): alu_out=0, alu_busy=0, alu_done=0, FSM=IDLE, iteration counter=0, prev-state register=0.
- Launch condition, evaluated at an edge with enable=1: core_state==EXECUTE_STATE, previous sampled core_state!=EXECUTE_STATE, FSM==IDLE.
  - Exactly one launch per EXECUTE entry.
  - Prev-state register updates only when enable=1.
- FSM states: IDLE, MUL, DIV.
- Single-cycle ops, from IDLE at the launch edge:
  - CMP (output_mux=1): alu_out <= {zeros, rs>rt, rs==rt, rs<rt}, unsigned.
  - ADD: alu_out <= (rs+rt) mod 2^DATA_WIDTH.
  - SUB: alu_out <= (rs-rt) mod 2^DATA_WIDTH.
  - alu_done=1 for the following cycle; FSM stays IDLE.
- MUL:
  - At launch, capture rs/rt into internal regs; FSM -> MUL; alu_busy=1.
  - Shift-add, one bit per enabled edge, DATA_WIDTH iterations.
  - At the DATA_WIDTH-th iteration edge: alu_out <= low DATA_WIDTH bits of the product; alu_busy->0; alu_done pulses; FSM -> IDLE.
  - Latency = DATA_WIDTH enabled cycles after launch.
- DIV:
  - Same capture as MUL, then restoring unsigned division, DATA_WIDTH iterations.
  - alu_out <= quotient.
  - rt==0 (captured): quotient = all ones. Still takes DATA_WIDTH cycles, so latency is uniform.
- Operands are sampled only at launch; rs/rt changes during busy are ignored.
- alu_out holds its value between operations; non-launching cycles never alter it.
- enable=0 during MUL/DIV: counter, partials, busy and FSM hold. Resumes when enable=1. alu_done stays 0 while frozen.
- Abort: core_state leaves EXECUTE_STATE while FSM!=IDLE (enable=1). At that edge FSM -> IDLE, alu_busy->0, no alu_done, alu_out unchanged.
- Simultaneous abort and final iteration: abort wins; no update.
- The core must remain in EXECUTE while alu_busy=1; this block does not stall the core itself.
- alu_done is never asserted in the same cycle as alu_busy=1.

Test Plan:
- DATA_WIDTH=8. Reset mid-MUL (rs=7, rt=9, cycle 3) -> alu_out=0, busy=0, done=0 immediately, before the next edge.
- ADD 200+100, then SUB 5-10 -> alu_out=44 then 251; each with a single-cycle done pulse and busy never high.
- CMP rs=3, rt=3, then rs=9, rt=2 -> alu_out=8'b010, then 8'b100. A held EXECUTE state must not relaunch or pulse done again.
- MUL rs=13, rt=21 -> alu_out=17 (273 mod 256) exactly 8 cycles after launch. Busy high for 8 cycles; rs/rt toggled during busy have no effect.
- DIV 200/7, then 5/0 -> 28 then 255, each after 8 cycles. Enable dropped 3 cycles mid-DIV stretches latency to 11 with an identical result.
- Abort: core_state leaves EXECUTE 4 cycles into DIV -> busy clears, no done, alu_out retains its previous value. The next EXECUTE entry launches normally.
